// File: rtl/lut_cam.sv
// Small content-addressable lookup table with insert/update, delete and a walking clear.
// Lookups are single-cycle registered; writes complete with a one-cycle done pulse.
module lut_cam #(
    parameter int NR_KEY      = 4,
    parameter int KEY_LEN     = 4,
    parameter int DATA_LEN    = 8,
    parameter int HAS_DEFAULT = 0
) (
    input  logic                         clk_i,
    input  logic                         rst_n_i,
    input  logic                         wr_valid_i,
    output logic                         wr_ready_o,
    input  logic [1:0]                   wr_op_i,
    input  logic [KEY_LEN-1:0]           wr_key_i,
    input  logic [DATA_LEN-1:0]          wr_data_i,
    output logic                         wr_done_o,
    output logic                         wr_err_o,
    input  logic                         rd_valid_i,
    input  logic [KEY_LEN-1:0]           rd_key_i,
    input  logic [DATA_LEN-1:0]          default_i,
    output logic                         rd_valid_o,
    output logic                         rd_hit_o,
    output logic [DATA_LEN-1:0]          rd_data_o,
    output logic [$clog2(NR_KEY+1)-1:0]  count_o
);
    localparam int CW = $clog2(NR_KEY + 1);
    localparam int IW = $clog2(NR_KEY);

    typedef enum logic {IDLE, CLEAR} state_t;

    state_t              state_reg, state_next;
    logic [IW-1:0]       idx_reg, idx_next;
    logic [CW-1:0]       count_reg, count_next;
    logic                done_reg, done_next;
    logic                err_reg, err_next;
    logic [NR_KEY-1:0]   valid_reg;
    logic [KEY_LEN-1:0]  key_reg  [NR_KEY];
    logic [DATA_LEN-1:0] data_reg [NR_KEY];

    logic [NR_KEY-1:0]   wr_match, rd_match, free_oh, set_valid, clr_valid, load_entry;
    logic                wr_hit, full, rd_hit;
    logic [DATA_LEN-1:0] hit_data, miss_data;
    logic                rd_valid_reg, rd_hit_reg;
    logic [DATA_LEN-1:0] rd_data_reg;

    genvar gi;
    generate
        for (gi = 0; gi < NR_KEY; gi++) begin : g_entry
            assign wr_match[gi] = valid_reg[gi] && (key_reg[gi] == wr_key_i);
            assign rd_match[gi] = valid_reg[gi] && (key_reg[gi] == rd_key_i);

            always_ff @(posedge clk_i or negedge rst_n_i) begin
                if (!rst_n_i)
                    valid_reg[gi] <= 1'b0;
                else if (clr_valid[gi])
                    valid_reg[gi] <= 1'b0;
                else if (set_valid[gi])
                    valid_reg[gi] <= 1'b1;
            end

            // Payload is qualified by valid_reg, so it needs no reset.
            always_ff @(posedge clk_i) begin
                if (load_entry[gi]) begin
                    key_reg[gi]  <= wr_key_i;
                    data_reg[gi] <= wr_data_i;
                end
            end
        end
    endgenerate

    assign wr_hit  = |wr_match;
    assign full    = &valid_reg;
    // Isolates the lowest clear bit of the valid vector: first free slot.
    assign free_oh = ~valid_reg & (valid_reg + NR_KEY'(1));

    always_comb begin
        state_next = state_reg;
        idx_next   = idx_reg;
        count_next = count_reg;
        done_next  = 1'b0;
        err_next   = 1'b0;
        set_valid  = '0;
        clr_valid  = '0;
        load_entry = '0;
        case (state_reg)
            IDLE: begin
                if (wr_valid_i) begin
                    done_next = 1'b1;
                    case (wr_op_i)
                        2'b00: begin
                            if (wr_hit) begin
                                load_entry = wr_match;
                            end else if (!full) begin
                                load_entry = free_oh;
                                set_valid  = free_oh;
                                count_next = count_reg + CW'(1);
                            end else begin
                                err_next = 1'b1;
                            end
                        end
                        2'b01: begin
                            if (wr_hit) begin
                                clr_valid  = wr_match;
                                count_next = count_reg - CW'(1);
                            end
                        end
                        2'b10: begin
                            state_next = CLEAR;
                            idx_next   = '0;
                            done_next  = 1'b0;
                        end
                        default: ;
                    endcase
                end
            end
            CLEAR: begin
                clr_valid = NR_KEY'(1) << idx_reg;
                if (valid_reg[idx_reg])
                    count_next = count_reg - CW'(1);
                idx_next = idx_reg + IW'(1);
                if (idx_reg == IW'(NR_KEY - 1)) begin
                    state_next = IDLE;
                    idx_next   = '0;
                    done_next  = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_reg <= IDLE;
            idx_reg   <= '0;
            count_reg <= '0;
            done_reg  <= 1'b0;
            err_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            idx_reg   <= idx_next;
            count_reg <= count_next;
            done_reg  <= done_next;
            err_reg   <= err_next;
        end
    end

    // Keys are unique, so OR-ing the matching entries selects the one hit.
    always_comb begin
        hit_data = '0;
        for (int i = 0; i < NR_KEY; i++)
            if (rd_match[i])
                hit_data = hit_data | data_reg[i];
    end

    assign rd_hit    = |rd_match;
    assign miss_data = (HAS_DEFAULT != 0) ? default_i : '0;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            rd_valid_reg <= 1'b0;
            rd_hit_reg   <= 1'b0;
            rd_data_reg  <= '0;
        end else begin
            rd_valid_reg <= rd_valid_i;
            rd_hit_reg   <= rd_valid_i && rd_hit;
            rd_data_reg  <= !rd_valid_i ? '0 : (rd_hit ? hit_data : miss_data);
        end
    end

    assign wr_ready_o = (state_reg == IDLE);
    assign wr_done_o  = done_reg;
    assign wr_err_o   = err_reg;
    assign rd_valid_o = rd_valid_reg;
    assign rd_hit_o   = rd_hit_reg;
    assign rd_data_o  = rd_data_reg;
    assign count_o    = count_reg;

endmodule

// File: tb/tb_lut_cam.sv
// Directed bench for lut_cam: a vector table of single-edge transactions plus
// hand-written clear, same-edge write/lookup and reset-during-clear sequences.
module tb_lut_cam;
    localparam int HAS_DEF = 0;
    localparam logic [7:0] MISS = (HAS_DEF != 0) ? 8'h3C : 8'h00;

    logic       clk_i = 1'b0;
    logic       rst_n_i;
    logic       wr_valid_i;
    logic       wr_ready_o;
    logic [1:0] wr_op_i;
    logic [3:0] wr_key_i;
    logic [7:0] wr_data_i;
    logic       wr_done_o;
    logic       wr_err_o;
    logic       rd_valid_i;
    logic [3:0] rd_key_i;
    logic [7:0] default_i;
    logic       rd_valid_o;
    logic       rd_hit_o;
    logic [7:0] rd_data_o;
    logic [2:0] count_o;

    int checks = 0;
    int errors = 0;

    lut_cam #(.NR_KEY(4), .KEY_LEN(4), .DATA_LEN(8), .HAS_DEFAULT(HAS_DEF)) dut (
        .clk_i(clk_i), .rst_n_i(rst_n_i),
        .wr_valid_i(wr_valid_i), .wr_ready_o(wr_ready_o), .wr_op_i(wr_op_i),
        .wr_key_i(wr_key_i), .wr_data_i(wr_data_i),
        .wr_done_o(wr_done_o), .wr_err_o(wr_err_o),
        .rd_valid_i(rd_valid_i), .rd_key_i(rd_key_i), .default_i(default_i),
        .rd_valid_o(rd_valid_o), .rd_hit_o(rd_hit_o), .rd_data_o(rd_data_o),
        .count_o(count_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic       wv;
        logic [1:0] op;
        logic [3:0] wk;
        logic [7:0] wd;
        logic       rv;
        logic [3:0] rk;
        logic       e_ready;
        logic       e_done;
        logic       e_err;
        logic       e_rvalid;
        logic       e_hit;
        logic [7:0] e_rdata;
        logic [2:0] e_count;
    } vec_t;

    vec_t vecs [20];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic drive(input logic wv, input logic [1:0] op, input logic [3:0] wk,
                         input logic [7:0] wd, input logic rv, input logic [3:0] rk);
        wr_valid_i = wv; wr_op_i = op; wr_key_i = wk; wr_data_i = wd;
        rd_valid_i = rv; rd_key_i = rk;
    endtask

    task automatic chk_rd(input string tag, input logic v, input logic h, input logic [7:0] d);
        chk({tag, "_rvalid"}, 32'(rd_valid_o), 32'(v));
        chk({tag, "_hit"},    32'(rd_hit_o),   32'(h));
        chk({tag, "_rdata"},  32'(rd_data_o),  32'(d));
    endtask

    task automatic set_vec(input int i, input logic wv, input logic [1:0] op, input logic [3:0] wk,
                           input logic [7:0] wd, input logic rv, input logic [3:0] rk,
                           input logic er, input logic ed, input logic ee, input logic erv,
                           input logic eh, input logic [7:0] erd, input logic [2:0] ec);
        vecs[i] = '{wv, op, wk, wd, rv, rk, er, ed, ee, erv, eh, erd, ec};
    endtask

    initial begin
        //          wv op     wk     wd     rv rk      rdy dn er rv hit data   cnt
        set_vec( 0, 1, 2'b00, 4'd3, 8'hA5, 0, 4'd0,   1, 1, 0, 0, 0, 8'h00, 3'd1);
        set_vec( 1, 0, 2'b00, 4'd0, 8'h00, 1, 4'd3,   1, 0, 0, 1, 1, 8'hA5, 3'd1);
        set_vec( 2, 1, 2'b01, 4'd3, 8'h00, 1, 4'd3,   1, 1, 0, 1, 1, 8'hA5, 3'd0);
        set_vec( 3, 0, 2'b00, 4'd0, 8'h00, 1, 4'd3,   1, 0, 0, 1, 0, MISS,  3'd0);
        set_vec( 4, 1, 2'b00, 4'd2, 8'h11, 0, 4'd0,   1, 1, 0, 0, 0, 8'h00, 3'd1);
        set_vec( 5, 1, 2'b00, 4'd2, 8'h22, 0, 4'd0,   1, 1, 0, 0, 0, 8'h00, 3'd1);
        set_vec( 6, 0, 2'b00, 4'd0, 8'h00, 1, 4'd2,   1, 0, 0, 1, 1, 8'h22, 3'd1);
        set_vec( 7, 1, 2'b01, 4'd2, 8'h00, 0, 4'd0,   1, 1, 0, 0, 0, 8'h00, 3'd0);
        set_vec( 8, 0, 2'b00, 4'd0, 8'h00, 1, 4'd2,   1, 0, 0, 1, 0, MISS,  3'd0);
        set_vec( 9, 1, 2'b01, 4'd9, 8'h00, 0, 4'd0,   1, 1, 0, 0, 0, 8'h00, 3'd0);
        set_vec(10, 1, 2'b00, 4'd1, 8'h10, 0, 4'd0,   1, 1, 0, 0, 0, 8'h00, 3'd1);
        set_vec(11, 1, 2'b00, 4'd2, 8'h20, 0, 4'd0,   1, 1, 0, 0, 0, 8'h00, 3'd2);
        set_vec(12, 1, 2'b00, 4'd3, 8'h30, 0, 4'd0,   1, 1, 0, 0, 0, 8'h00, 3'd3);
        set_vec(13, 1, 2'b00, 4'd4, 8'h40, 0, 4'd0,   1, 1, 0, 0, 0, 8'h00, 3'd4);
        set_vec(14, 1, 2'b00, 4'd5, 8'h50, 1, 4'd4,   1, 1, 1, 1, 1, 8'h40, 3'd4);
        set_vec(15, 0, 2'b00, 4'd0, 8'h00, 1, 4'd5,   1, 0, 0, 1, 0, MISS,  3'd4);
        set_vec(16, 1, 2'b11, 4'd1, 8'hFF, 0, 4'd0,   1, 1, 0, 0, 0, 8'h00, 3'd4);
        set_vec(17, 1, 2'b00, 4'd3, 8'h33, 0, 4'd0,   1, 1, 0, 0, 0, 8'h00, 3'd4);
        set_vec(18, 0, 2'b00, 4'd0, 8'h00, 1, 4'd3,   1, 0, 0, 1, 1, 8'h33, 3'd4);
        set_vec(19, 0, 2'b00, 4'd0, 8'h00, 1, 4'd1,   1, 0, 0, 1, 1, 8'h10, 3'd4);

        default_i = 8'h3C;
        drive(0, 2'b00, 4'd0, 8'd0, 0, 4'd0);
        rst_n_i = 1'b0;
        #12;
        chk("reset_count", 32'(count_o), 32'd0);
        chk("reset_done",  32'(wr_done_o), 32'd0);
        chk_rd("reset", 0, 0, 8'h00);
        @(negedge clk_i);
        rst_n_i = 1'b1;
        #1;
        chk("reset_ready", 32'(wr_ready_o), 32'd1);

        for (int i = 0; i < 20; i++) begin
            drive(vecs[i].wv, vecs[i].op, vecs[i].wk, vecs[i].wd, vecs[i].rv, vecs[i].rk);
            tick();
            chk($sformatf("vec%0d_ready", i), 32'(wr_ready_o), 32'(vecs[i].e_ready));
            chk($sformatf("vec%0d_done", i),  32'(wr_done_o),  32'(vecs[i].e_done));
            chk($sformatf("vec%0d_err", i),   32'(wr_err_o),   32'(vecs[i].e_err));
            chk_rd($sformatf("vec%0d", i), vecs[i].e_rvalid, vecs[i].e_hit, vecs[i].e_rdata);
            chk($sformatf("vec%0d_count", i), 32'(count_o), 32'(vecs[i].e_count));
            $display("vec %0d: wr v=%0d op=%0d key=%0h data=%0h rd v=%0d key=%0h -> done=%0d err=%0d hit=%0d data=%0h count=%0d",
                     i, vecs[i].wv, vecs[i].op, vecs[i].wk, vecs[i].wd, vecs[i].rv, vecs[i].rk,
                     wr_done_o, wr_err_o, rd_hit_o, rd_data_o, count_o);
        end

        // Clear of a full table (keys 1,2,3,4 at slots 0..3); a write is held valid throughout.
        drive(1, 2'b10, 4'd0, 8'd0, 0, 4'd0);
        tick();
        chk("clr_acc_ready", 32'(wr_ready_o), 32'd0);
        chk("clr_acc_done",  32'(wr_done_o),  32'd0);
        chk("clr_acc_count", 32'(count_o),    32'd4);
        $display("clear accepted");
        drive(1, 2'b00, 4'd8, 8'h88, 1, 4'd1);
        tick();
        chk("clr1_ready", 32'(wr_ready_o), 32'd0);
        chk("clr1_done",  32'(wr_done_o),  32'd0);
        chk("clr1_count", 32'(count_o),    32'd3);
        chk_rd("clr1", 1, 1, 8'h10);
        $display("clear cycle 1: count=%0d hit=%0d", count_o, rd_hit_o);
        tick();
        chk("clr2_ready", 32'(wr_ready_o), 32'd0);
        chk("clr2_count", 32'(count_o),    32'd2);
        chk_rd("clr2", 1, 0, MISS);
        $display("clear cycle 2: count=%0d hit=%0d", count_o, rd_hit_o);
        rd_key_i = 4'd4;
        tick();
        chk("clr3_ready", 32'(wr_ready_o), 32'd0);
        chk("clr3_done",  32'(wr_done_o),  32'd0);
        chk("clr3_count", 32'(count_o),    32'd1);
        chk_rd("clr3", 1, 1, 8'h40);
        $display("clear cycle 3: count=%0d hit=%0d", count_o, rd_hit_o);
        rd_valid_i = 1'b0;
        tick();
        chk("clr4_ready", 32'(wr_ready_o), 32'd1);
        chk("clr4_done",  32'(wr_done_o),  32'd1);
        chk("clr4_count", 32'(count_o),    32'd0);
        $display("clear cycle 4: done=%0d count=%0d", wr_done_o, count_o);
        drive(0, 2'b00, 4'd0, 8'd0, 1, 4'd8);
        tick();
        chk("clr_after_done",  32'(wr_done_o), 32'd0);
        chk("clr_after_count", 32'(count_o),   32'd0);
        chk_rd("clr_after_key8", 1, 0, MISS);
        $display("after clear: held write ignored, count=%0d", count_o);

        // Insert and lookup the same key on one edge.
        drive(1, 2'b00, 4'd7, 8'h01, 1, 4'd7);
        tick();
        chk("same_edge_done", 32'(wr_done_o), 32'd1);
        chk_rd("same_edge", 1, 0, MISS);
        drive(0, 2'b00, 4'd0, 8'd0, 1, 4'd7);
        tick();
        chk_rd("same_edge_next", 1, 1, 8'h01);
        chk("same_edge_count", 32'(count_o), 32'd1);
        $display("same-edge insert/lookup key 7: next hit=%0d data=%0h", rd_hit_o, rd_data_o);

        // Reset in the middle of a clear walk.
        drive(1, 2'b00, 4'd8, 8'h02, 0, 4'd0);
        tick();
        drive(1, 2'b10, 4'd0, 8'd0, 0, 4'd0);
        tick();
        drive(0, 2'b00, 4'd0, 8'd0, 1, 4'd8);
        tick();
        chk("pre_rst_hit", 32'(rd_hit_o), 32'd1);
        #2;
        rst_n_i = 1'b0;
        #1;
        chk("mid_rst_count", 32'(count_o), 32'd0);
        chk("mid_rst_done",  32'(wr_done_o), 32'd0);
        chk_rd("mid_rst", 0, 0, 8'h00);
        $display("reset asserted mid-clear: count=%0d rvalid=%0d", count_o, rd_valid_o);
        drive(0, 2'b00, 4'd0, 8'd0, 0, 4'd0);
        @(negedge clk_i);
        rst_n_i = 1'b1;
        for (int c = 0; c < 6; c++) begin
            rd_valid_i = 1'b1;
            rd_key_i   = (c % 2 == 0) ? 4'd7 : 4'd8;
            tick();
            chk($sformatf("post_rst%0d_done", c), 32'(wr_done_o), 32'd0);
            chk($sformatf("post_rst%0d_ready", c), 32'(wr_ready_o), 32'd1);
            chk_rd($sformatf("post_rst%0d", c), 1, 0, MISS);
            $display("post-reset cycle %0d: key=%0h hit=%0d done=%0d", c, rd_key_i, rd_hit_o, wr_done_o);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
